// File: rtl/mem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_line_responder: latency-modelled line memory behind the caches.      |
// | Optional: MEMRESP_CWF_EN (critical-word-first reads).   Rev 1.0          |
// +--------------------------------------------------------------------------+
module mem_line_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LINE_WORDS  = 4,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic        wr_valid_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ready_o,
    output logic        wr_done_o,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        rd_last_o,
    input  logic        rd_ready_i,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int LW = AW - OW;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WBURST = 3'd1,
        S_WAIT   = 3'd2,
        S_RBURST = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] line_q,  line_d;
    logic [OW-1:0] start_q, start_d;
    logic [OW-1:0] beat_q,  beat_d;
    logic          we_q,    we_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [31:0]   RAM [DEPTH_WORDS];

    logic [OW-1:0] w_offset;
    logic [AW-1:0] w_word_addr;
    logic [OW-1:0] w_req_start;
    logic          w_ram_we;
    logic          unused_addr_bits;

    // Offset wraps inside the line, so no beat ever touches a neighbouring line.
    assign w_offset    = start_q + beat_q;
    assign w_word_addr = {line_q, w_offset};

`ifdef MEMRESP_CWF_EN
    assign w_req_start = req_we_i ? '0 : req_addr_i[OW+1:2];
`else
    assign w_req_start = '0;
`endif

    assign unused_addr_bits = ^{req_addr_i[31:AW+2], req_addr_i[OW+1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            start_q <= '0;
            beat_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            start_q <= start_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        start_d     = start_q;
        beat_d      = beat_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        req_ready_o = 1'b0;
        wr_ready_o  = 1'b0;
        wr_done_o   = 1'b0;
        rd_valid_o  = 1'b0;
        rd_last_o   = 1'b0;
        rd_data_o   = '0;
        busy_o      = 1'b1;
        w_ram_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The state register is already IDLE during reset; keep ready low there.
                req_ready_o = rst_ni;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    line_d  = req_addr_i[AW+1:OW+2];
                    start_d = w_req_start;
                    we_d    = req_we_i;
                    cnt_d   = CW'(LATENCY);
                    beat_d  = '0;
                    if (req_we_i) begin
                        state_d = S_WBURST;
                    end else if (LATENCY == 0) begin
                        state_d = S_RBURST;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WBURST: begin
                wr_ready_o = 1'b1;
                if (wr_valid_i) begin
                    w_ram_we = 1'b1;
                    beat_d   = beat_q + OW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = (LATENCY == 0) ? S_DONE : S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = we_q ? S_DONE : S_RBURST;
                end
            end

            S_RBURST: begin
                rd_valid_o = 1'b1;
                rd_data_o  = RAM[w_word_addr];
                rd_last_o  = (beat_q == LAST_BEAT);
                if (rd_ready_i) begin
                    beat_d = beat_q + OW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DONE: begin
                wr_done_o = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // No reset on the array: contents survive reset by design.
    always_ff @(posedge clk_i) begin
        if (w_ram_we) begin
            RAM[w_word_addr] <= wr_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
// Bench for mem_line_responder: directed plan cases plus randomized line traffic
// checked against an array model of the backing store.
module tb_mem_line_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LINE  = 4;
    localparam int unsigned LAT   = 4;
`ifdef MEMRESP_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        req_valid, req_ready, req_we, wr_valid, wr_ready, wr_done;
    logic        rd_valid, rd_last, rd_ready, busy;
    logic [31:0] req_addr, wr_data, rd_data;

    logic        req_valid0, req_ready0, req_we0, wr_valid0, wr_ready0, wr_done0;
    logic        rd_valid0, rd_last0, rd_ready0, busy0;
    logic [31:0] req_addr0, wr_data0, rd_data0;

    mem_line_responder #(.DEPTH_WORDS(DEPTH), .LINE_WORDS(LINE), .LATENCY(LAT)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_we_i(req_we),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready), .wr_done_o(wr_done),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_last_o(rd_last), .rd_ready_i(rd_ready),
        .busy_o(busy)
    );

    mem_line_responder #(.DEPTH_WORDS(DEPTH), .LINE_WORDS(LINE), .LATENCY(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_addr_i(req_addr0), .req_we_i(req_we0),
        .wr_valid_i(wr_valid0), .wr_data_i(wr_data0), .wr_ready_o(wr_ready0), .wr_done_o(wr_done0),
        .rd_valid_o(rd_valid0), .rd_data_o(rd_data0), .rd_last_o(rd_last0), .rd_ready_i(rd_ready0),
        .busy_o(busy0)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model_mem [DEPTH];

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Word index of beat i of a line transfer, straight from the addressing rules.
    function automatic int unsigned exp_word(input logic [31:0] addr, input int unsigned i,
                                             input bit is_read);
        int unsigned word, base, start;
        word  = addr >> 2;
        base  = word - (word % LINE);
        start = (is_read && CWF) ? (word % LINE) : 0;
        return (base + ((start + i) % LINE)) % DEPTH;
    endfunction

    task automatic issue(input logic [31:0] addr, input logic we);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("req_ready_before_issue", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_we    = 1'($urandom);
        chk1("busy_after_accept", busy, 1'b1);
        chk1("req_ready_after_accept", req_ready, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall_beat, input int stall_len);
        int n;
        logic [31:0] exp;
        issue(addr, 1'b0);
        n = 1;
        while (rd_valid !== 1'b1 && n < int'(LAT) + 20) begin
            @(negedge clk);
            n++;
        end
        chk32("rd_first_beat_latency", 32'(n), 32'(LAT + 1));
        for (int i = 0; i < int'(LINE); i++) begin
            exp = model_mem[exp_word(addr, i, 1'b1)];
            chk1("rd_valid", rd_valid, 1'b1);
            chk32("rd_data", rd_data, exp);
            chk1("rd_last", rd_last, i == int'(LINE) - 1);
            if (i == stall_beat) begin
                rd_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk1("rd_valid_stall", rd_valid, 1'b1);
                    chk32("rd_data_stall", rd_data, exp);
                    chk1("rd_last_stall", rd_last, i == int'(LINE) - 1);
                end
                rd_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk1("req_ready_after_read", req_ready, 1'b1);
        chk1("busy_after_read", busy, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [LINE*32-1:0] d,
                            input int gap_after, input int gap_len);
        int n;
        int unsigned idx;
        issue(addr, 1'b1);
        for (int i = 0; i < int'(LINE); i++) begin
            chk1("wr_ready", wr_ready, 1'b1);
            wr_valid = 1'b1;
            wr_data  = d[i*32 +: 32];
            @(negedge clk);
            if (i == gap_after && i != int'(LINE) - 1) begin
                wr_valid = 1'b0;
                repeat (gap_len) begin
                    chk1("wr_ready_gap", wr_ready, 1'b1);
                    @(negedge clk);
                end
            end
        end
        // Junk beats offered after the burst must never reach the array.
        wr_valid = 1'b1;
        wr_data  = $urandom;
        n = 1;
        while (wr_done !== 1'b1 && n < int'(LAT) + 20) begin
            @(negedge clk);
            n++;
        end
        chk32("wr_done_latency", 32'(n), 32'(LAT + 1));
        wr_valid = 1'b0;
        @(negedge clk);
        chk1("wr_done_single_pulse", wr_done, 1'b0);
        chk1("req_ready_after_write", req_ready, 1'b1);
        for (int i = 0; i < int'(LINE); i++) begin
            idx = exp_word(addr, i, 1'b0);
            model_mem[idx] = d[i*32 +: 32];
            chk32("ram_after_write", u_dut.RAM[idx], model_mem[idx]);
        end
    endtask

    initial begin
        logic [LINE*32-1:0] d;
        logic [31:0]        a;
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        req_valid0 = 1'b0; req_addr0 = '0; req_we0 = 1'b0; wr_valid0 = 1'b0; wr_data0 = '0; rd_ready0 = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = $urandom;
        model_mem[4] = 32'd11; model_mem[5] = 32'd22; model_mem[6] = 32'd33; model_mem[7] = 32'd44;
        for (int i = 0; i < int'(DEPTH); i++) begin
            u_dut.RAM[i]  = model_mem[i];
            u_dut0.RAM[i] = model_mem[i];
        end
        repeat (3) @(negedge clk);

        chk1("reset_req_ready", req_ready, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_wr_ready", wr_ready, 1'b0);
        chk1("reset_wr_done", wr_done, 1'b0);
        chk1("reset_rd_valid", rd_valid, 1'b0);
        chk1("reset_rd_last", rd_last, 1'b0);
        chk32("reset_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("idle_req_ready", req_ready, 1'b1);
        chk1("idle_busy", busy, 1'b0);

        // Zero latency, address 0x400 aliases word 0.
        req_valid0 = 1'b1; req_addr0 = 32'h400; req_we0 = 1'b0;
        @(negedge clk);
        req_valid0 = 1'b0;
        for (int i = 0; i < int'(LINE); i++) begin
            chk1("l0_rd_valid", rd_valid0, 1'b1);
            chk32("l0_rd_data", rd_data0, model_mem[i]);
            chk1("l0_rd_last", rd_last0, i == int'(LINE) - 1);
            @(negedge clk);
        end
        chk1("l0_req_ready_after_read", req_ready0, 1'b1);
        req_valid0 = 1'b1; req_addr0 = 32'h404; req_we0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        for (int i = 0; i < int'(LINE); i++) begin
            wr_valid0 = 1'b1;
            wr_data0  = 32'hC0DE_0000 + 32'(i);
            @(negedge clk);
        end
        wr_valid0 = 1'b0;
        chk1("l0_wr_done", wr_done0, 1'b1);
        @(negedge clk);
        chk1("l0_wr_done_pulse", wr_done0, 1'b0);
        for (int i = 0; i < int'(LINE); i++) begin
            chk32("l0_ram", u_dut0.RAM[i], 32'hC0DE_0000 + 32'(i));
        end

        do_read(32'h10, int'(LINE), 0);
        d = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        do_write(32'h20, d, 1, 2);
        do_read(32'h20, 2, 3);
        do_read(32'h18, int'(LINE), 0);

        // Reset lands after two accepted beats of a write.
        issue(32'h40, 1'b1);
        wr_valid = 1'b1; wr_data = 32'h1111_AAAA;
        @(negedge clk);
        wr_data = 32'h2222_BBBB;
        @(negedge clk);
        wr_data = 32'h3333_CCCC;
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_req_ready", req_ready, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_wr_ready", wr_ready, 1'b0);
        chk1("midrst_wr_done", wr_done, 1'b0);
        chk1("midrst_rd_valid", rd_valid, 1'b0);
        chk32("midrst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        model_mem[16] = 32'h1111_AAAA;
        model_mem[17] = 32'h2222_BBBB;
        for (int i = 16; i < 20; i++) chk32("midrst_ram", u_dut.RAM[i], model_mem[i]);
        @(negedge clk);
        chk1("midrst_req_ready_after", req_ready, 1'b1);
        do_read(32'h40, int'(LINE), 0);

        for (int t = 0; t < 24; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                do_write(a, d, $urandom_range(0, LINE - 1), $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, LINE), $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
